// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : Hazard and forwarding controller for an in-order MIPS pipeline.
//             A shifting scoreboard tracks every in-flight instruction from
//             EX (entry 1) to WB (entry DEPTH). For the instruction in ID it
//             produces the EX forwarding selects, the load-use stall and the
//             branch flush, and it counts stall and flush events.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W      register address width (address 0 is the zero register)
//    DEPTH       scoreboard entries after ID, 2..8
//    LOAD_STAGE  first entry index where a load result is forwardable
//    SEL_W       width of the forwarding selects
//  Ports
//    clk, rst            clock (state moves on the falling edge), sync reset
//    i_id_*              decoded fields of the instruction currently in ID
//    i_ex_branch_taken   branch in EX resolved taken this cycle
//    o_stall             hold PC and IF/ID, bubble into EX (combinational)
//    o_flush             kill IF/ID and ID/EX (combinational)
//    o_ex_valid          EX instruction is real (registered)
//    o_fwd_rs_ex/rt_ex   0 = register file, j = result of entry j (registered)
//    o_stall_cnt/flush_cnt  saturating 16-bit event counters
// ============================================================================
module hazard_scoreboard #(
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 3,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_id_valid,
  input  logic [ADDR_W-1:0] i_id_rs_addr,
  input  logic [ADDR_W-1:0] i_id_rt_addr,
  input  logic              i_id_uses_rs,
  input  logic              i_id_uses_rt,
  input  logic              i_id_reg_write,
  input  logic              i_id_is_load,
  input  logic [ADDR_W-1:0] i_id_dst_addr,
  input  logic              i_ex_branch_taken,
  output logic              o_stall,
  output logic              o_flush,
  output logic              o_ex_valid,
  output logic [SEL_W-1:0]  o_fwd_rs_ex,
  output logic [SEL_W-1:0]  o_fwd_rt_ex,
  output logic [15:0]       o_stall_cnt,
  output logic [15:0]       o_flush_cnt
);

  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  // Scoreboard entries, index 1 = EX ... DEPTH = WB.
  logic [DEPTH:1]    r_vld;
  logic [DEPTH:1]    r_rw;
  logic [DEPTH:1]    r_ld;
  logic [ADDR_W-1:0] r_dst [1:DEPTH];

  logic [SEL_W-1:0]  r_fwd_rs;
  logic [SEL_W-1:0]  r_fwd_rt;
  logic [15:0]       r_stall_cnt;
  logic [15:0]       r_flush_cnt;

  logic              w_rs_live;
  logic              w_rt_live;
  logic [DEPTH:1]    w_rs_match;
  logic [DEPTH:1]    w_rt_match;
  logic [SEL_W-1:0]  w_fwd_rs;
  logic [SEL_W-1:0]  w_fwd_rt;
  logic              w_load_hit;
  logic              w_flush;
  logic              w_stall;
  logic              w_issue;

  // A source only participates when it is really read and is not $0.
  assign w_rs_live = i_id_valid & i_id_uses_rs & (i_id_rs_addr != '0);
  assign w_rt_live = i_id_valid & i_id_uses_rt & (i_id_rt_addr != '0);

  generate
    for (genvar gk = 1; gk <= DEPTH; gk++) begin : g_match
      assign w_rs_match[gk] = w_rs_live & r_vld[gk] & r_rw[gk] &
                              (r_dst[gk] == i_id_rs_addr);
      assign w_rt_match[gk] = w_rt_live & r_vld[gk] & r_rw[gk] &
                              (r_dst[gk] == i_id_rt_addr);
    end
  endgenerate

  // Scan oldest to youngest so the youngest match overwrites. Entry DEPTH is
  // excluded: WB writes the register file before ID reads it, so select 0.
  // The consumer reaches EX one edge later, hence the k+1 select value.
  always_comb begin
    w_fwd_rs = '0;
    w_fwd_rt = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (w_rs_match[k]) begin
        w_fwd_rs = SEL_W'(k + 1);
      end
      if (w_rt_match[k]) begin
        w_fwd_rt = SEL_W'(k + 1);
      end
    end
  end

  // A load whose result will still be too young when the consumer reaches EX
  // (k+1 below LOAD_STAGE) forces a stall.
  always_comb begin
    w_load_hit = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if ((k + 1) < LOAD_STAGE) begin
        if (r_ld[k] & (w_rs_match[k] | w_rt_match[k])) begin
          w_load_hit = 1'b1;
        end
      end
    end
  end

  // Flush wins over stall: the ID instruction is discarded anyway.
  assign w_flush = i_ex_branch_taken;
  assign w_stall = ~w_flush & w_load_hit;
  assign w_issue = i_id_valid & ~w_flush & ~w_stall;

  always_ff @(negedge clk) begin
    if (rst) begin
      r_vld       <= '0;
      r_rw        <= '0;
      r_ld        <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        r_dst[k] <= '0;
      end
      r_fwd_rs    <= '0;
      r_fwd_rt    <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        r_vld[k] <= r_vld[k-1];
        r_rw[k]  <= r_rw[k-1];
        r_ld[k]  <= r_ld[k-1];
        r_dst[k] <= r_dst[k-1];
      end
      // Entry 1 receives either the ID instruction or an all-zero bubble.
      r_vld[1] <= w_issue;
      r_rw[1]  <= w_issue & i_id_reg_write;
      r_ld[1]  <= w_issue & i_id_is_load;
      r_dst[1] <= w_issue ? i_id_dst_addr : '0;
      r_fwd_rs <= w_issue ? w_fwd_rs : '0;
      r_fwd_rt <= w_issue ? w_fwd_rt : '0;
      if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_flush && (r_flush_cnt != c_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign o_stall     = w_stall;
  assign o_flush     = w_flush;
  assign o_ex_valid  = r_vld[1];
  assign o_fwd_rs_ex = r_fwd_rs;
  assign o_fwd_rt_ex = r_fwd_rt;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Purpose  : Self-checking bench for hazard_scoreboard. Two instances share
//             the stimulus: u_d3 (DEPTH=3, LOAD_STAGE=3) and u_d5 (DEPTH=5,
//             LOAD_STAGE=4). Expected registered outputs are queued when an
//             instruction is driven and compared after the next falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       rw;
    logic       ld;
    logic [4:0] dst;
  } instr_t;

  typedef struct {
    string      tag;
    logic       exv;
    logic [3:0] rs;
    logic [3:0] rt;
  } exp_t;

  logic       clk;
  logic       rst;
  instr_t     r_in;
  logic       r_br;

  logic       w3_stall, w3_flush, w3_exv;
  logic [1:0] w3_rs, w3_rt;
  logic [15:0] w3_scnt, w3_fcnt;
  logic       w5_stall, w5_flush, w5_exv;
  logic [2:0] w5_rs, w5_rt;
  logic [15:0] w5_scnt, w5_fcnt;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  hazard_scoreboard #(.ADDR_W(5), .DEPTH(3), .LOAD_STAGE(3)) u_d3 (
    .clk(clk), .rst(rst),
    .i_id_valid(r_in.v), .i_id_rs_addr(r_in.rs), .i_id_rt_addr(r_in.rt),
    .i_id_uses_rs(r_in.urs), .i_id_uses_rt(r_in.urt),
    .i_id_reg_write(r_in.rw), .i_id_is_load(r_in.ld),
    .i_id_dst_addr(r_in.dst), .i_ex_branch_taken(r_br),
    .o_stall(w3_stall), .o_flush(w3_flush), .o_ex_valid(w3_exv),
    .o_fwd_rs_ex(w3_rs), .o_fwd_rt_ex(w3_rt),
    .o_stall_cnt(w3_scnt), .o_flush_cnt(w3_fcnt)
  );

  hazard_scoreboard #(.ADDR_W(5), .DEPTH(5), .LOAD_STAGE(4)) u_d5 (
    .clk(clk), .rst(rst),
    .i_id_valid(r_in.v), .i_id_rs_addr(r_in.rs), .i_id_rt_addr(r_in.rt),
    .i_id_uses_rs(r_in.urs), .i_id_uses_rt(r_in.urt),
    .i_id_reg_write(r_in.rw), .i_id_is_load(r_in.ld),
    .i_id_dst_addr(r_in.dst), .i_ex_branch_taken(r_br),
    .o_stall(w5_stall), .o_flush(w5_flush), .o_ex_valid(w5_exv),
    .o_fwd_rs_ex(w5_rs), .o_fwd_rt_ex(w5_rt),
    .o_stall_cnt(w5_scnt), .o_flush_cnt(w5_fcnt)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t f_add(input int d, input int s, input int t);
    instr_t i;
    i = '0;
    i.v = 1'b1; i.rs = 5'(s); i.rt = 5'(t); i.urs = 1'b1; i.urt = 1'b1;
    i.rw = 1'b1; i.dst = 5'(d);
    return i;
  endfunction

  function automatic instr_t f_lw(input int d, input int base);
    instr_t i;
    i = '0;
    i.v = 1'b1; i.rs = 5'(base); i.rt = 5'(d); i.urs = 1'b1;
    i.rw = 1'b1; i.ld = 1'b1; i.dst = 5'(d);
    return i;
  endfunction

  // Drive one ID cycle, check the combinational outputs of the chosen
  // instance, queue the expected ID/EX contents and compare after the edge.
  task automatic step(input string tag, input int dut, input instr_t ins,
                      input logic br, input logic e_stall, input logic e_exv,
                      input int e_rs, input int e_rt);
    exp_t e;
    r_in = ins;
    r_br = br;
    #1;
    if (dut == 0) begin
      check({tag, ".stall"}, 32'(w3_stall), 32'(e_stall));
      check({tag, ".flush"}, 32'(w3_flush), 32'(br));
    end else begin
      check({tag, ".stall"}, 32'(w5_stall), 32'(e_stall));
      check({tag, ".flush"}, 32'(w5_flush), 32'(br));
    end
    e.tag = tag; e.exv = e_exv; e.rs = 4'(e_rs); e.rt = 4'(e_rt);
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    e = exp_q.pop_front();
    if (dut == 0) begin
      check({e.tag, ".ex_valid"}, 32'(w3_exv), 32'(e.exv));
      check({e.tag, ".fwd_rs"},   32'(w3_rs),  32'(e.rs));
      check({e.tag, ".fwd_rt"},   32'(w3_rt),  32'(e.rt));
    end else begin
      check({e.tag, ".ex_valid"}, 32'(w5_exv), 32'(e.exv));
      check({e.tag, ".fwd_rs"},   32'(w5_rs),  32'(e.rs));
      check({e.tag, ".fwd_rt"},   32'(w5_rt),  32'(e.rt));
    end
  endtask

  task automatic drain(input int dut, input int n);
    for (int i = 0; i < n; i++) begin
      step("drain", dut, '0, 1'b0, 1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      r_in = instr_t'($urandom);
      r_br = 1'($urandom);
      #1;
      if (i == 1) begin
        check("rst.stall3", 32'(w3_stall), 32'd0);
        check("rst.stall5", 32'(w5_stall), 32'd0);
        check("rst.flush3", 32'(w3_flush), 32'(r_br));
      end
      @(negedge clk);
    end
    #1;
    check("rst.exv",  32'(w3_exv),  32'd0);
    check("rst.rs",   32'(w3_rs),   32'd0);
    check("rst.rt",   32'(w3_rt),   32'd0);
    check("rst.scnt", 32'(w3_scnt), 32'd0);
    check("rst.fcnt", 32'(w3_fcnt), 32'd0);
    check("rst.fcnt5", 32'(w5_fcnt), 32'd0);
    rst  = 1'b0;
    r_in = '0;
    r_br = 1'b0;
  endtask

  initial begin
    instr_t c;
    rst  = 1'b1;
    r_in = '0;
    r_br = 1'b0;
    #1;
    do_reset();

    // Back-to-back ALU dependency: forward from entry 2.
    step("add3",   0, f_add(3, 1, 2), 1'b0, 1'b0, 1'b1, 0, 0);
    step("add5a",  0, f_add(5, 3, 3), 1'b0, 1'b0, 1'b1, 2, 2);
    drain(0, 3);
    // One unrelated instruction in between: forward from entry 3.
    step("add3b",  0, f_add(3, 1, 2), 1'b0, 1'b0, 1'b1, 0, 0);
    step("add6",   0, f_add(6, 1, 2), 1'b0, 1'b0, 1'b1, 0, 0);
    step("add5b",  0, f_add(5, 3, 3), 1'b0, 1'b0, 1'b1, 3, 3);
    drain(0, 3);

    // Load-use: one stall cycle, then forward from entry 3.
    step("lw3",    0, f_lw(3, 1),     1'b0, 1'b0, 1'b1, 0, 0);
    step("subStl", 0, f_add(4, 3, 1), 1'b0, 1'b1, 1'b0, 0, 0);
    check("lu.scnt_mid", 32'(w3_scnt), 32'd1);
    step("subGo",  0, f_add(4, 3, 1), 1'b0, 1'b0, 1'b1, 3, 0);
    check("lu.scnt", 32'(w3_scnt), 32'd1);
    drain(0, 3);

    // Taken branch with a load-use pending: flush wins, no stall counted.
    step("lw3f",   0, f_lw(3, 1),     1'b0, 1'b0, 1'b1, 0, 0);
    step("subFl",  0, f_add(4, 3, 1), 1'b1, 1'b0, 1'b0, 0, 0);
    check("fl.fcnt", 32'(w3_fcnt), 32'd1);
    check("fl.scnt", 32'(w3_scnt), 32'd1);
    drain(0, 3);

    // Writes to $0 never forward and never stall.
    step("lw0",    0, f_lw(0, 1),     1'b0, 1'b0, 1'b1, 0, 0);
    step("rd0",    0, f_add(9, 0, 0), 1'b0, 1'b0, 1'b1, 0, 0);
    drain(0, 3);

    // Two writers of $7: youngest wins; unused rt never forwards.
    step("p7a",    0, f_add(7, 1, 2), 1'b0, 1'b0, 1'b1, 0, 0);
    step("p7b",    0, f_add(7, 1, 2), 1'b0, 1'b0, 1'b1, 0, 0);
    c = f_add(9, 7, 7);
    c.urt = 1'b0;
    step("c7",     0, c,              1'b0, 1'b0, 1'b1, 2, 0);
    drain(0, 3);

    // Producer already in WB (entry DEPTH): read the register file.
    step("p8",     0, f_add(8, 1, 2),   1'b0, 1'b0, 1'b1, 0, 0);
    step("x10",    0, f_add(10, 1, 2),  1'b0, 1'b0, 1'b1, 0, 0);
    step("x11",    0, f_add(11, 1, 2),  1'b0, 1'b0, 1'b1, 0, 0);
    step("c8",     0, f_add(12, 8, 8),  1'b0, 1'b0, 1'b1, 0, 0);
    drain(0, 3);

    // Reset in the middle of a load-use stall.
    step("lw3r",   0, f_lw(3, 1),     1'b0, 1'b0, 1'b1, 0, 0);
    rst = 1'b1;
    step("subRst", 0, f_add(4, 3, 1), 1'b0, 1'b1, 1'b0, 0, 0);
    check("rs.scnt", 32'(w3_scnt), 32'd0);
    rst = 1'b0;
    step("subAft", 0, f_add(4, 3, 1), 1'b0, 1'b0, 1'b1, 0, 0);

    // Deeper variant: DEPTH=5, LOAD_STAGE=4.
    do_reset();
    step("d5.lw2", 1, f_lw(2, 1),     1'b0, 1'b0, 1'b1, 0, 0);
    step("d5.st1", 1, f_add(9, 2, 2), 1'b0, 1'b1, 1'b0, 0, 0);
    step("d5.st2", 1, f_add(9, 2, 2), 1'b0, 1'b1, 1'b0, 0, 0);
    step("d5.go",  1, f_add(9, 2, 2), 1'b0, 1'b0, 1'b1, 4, 4);
    check("d5.scnt", 32'(w5_scnt), 32'd2);

    // Flush counter saturation.
    r_in = '0;
    r_br = 1'b1;
    repeat (65534) @(negedge clk);
    #1;
    check("sat.fcnt_fffe", 32'(w5_fcnt), 32'h0000FFFE);
    repeat (70000 - 65534) @(negedge clk);
    #1;
    check("sat.fcnt5", 32'(w5_fcnt), 32'h0000FFFF);
    check("sat.fcnt3", 32'(w3_fcnt), 32'h0000FFFF);
    r_br = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the in-order MIPS pipeline, replacing the fixed two-source forwarding unit. It tracks every in-flight register-writing instruction from EX through WB in a shifting scoreboard. For the instruction in ID it computes the EX-stage forwarding selects, the load-use stall and the branch flush. Pipeline depth and load-result latency are parameters, so the same block serves the 5-stage core and deeper variants; stall and flush events are also counted.

## Interface
- ADDR_W, 5: register address width; address 0 is the hard-wired zero register.
- DEPTH, 3: scoreboard entries after ID; entry 1 = EX, entry DEPTH = WB. Legal range 2..8.
- LOAD_STAGE, 3: first entry index at which a load result can be forwarded. Legal range 2..DEPTH.
- SEL_W, $clog2(DEPTH+1): width of the forwarding selects.
- clk  in  1  clock; all state updates on the falling edge, matching the pipeline registers.
- rst  in  1  reset, synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs_addr, id_rt_addr  in  ADDR_W  source register addresses.
- id_uses_rs, id_uses_rt  in  1  the source is actually read.
- id_reg_write  in  1  the ID instruction writes a register.
- id_is_load  in  1  the ID instruction is a load (lw).
- id_dst_addr  in  ADDR_W  destination register, already resolved between rt and rd.
- ex_branch_taken  in  1  the branch in EX resolved taken this cycle.
- stall  out  1  combinational; hold PC and IF/ID, and inject a bubble into EX.
- flush  out  1  combinational; equals ex_branch_taken; kill IF/ID and ID/EX.
- ex_valid  out  1  registered; the EX instruction is real.
- fwd_rs_ex, fwd_rt_ex  out  SEL_W  registered; 0 = register file, j (2..DEPTH) = take the result from entry j.
- stall_cnt, flush_cnt  out  16  saturating event counters.

## Operation
- Each scoreboard entry k holds {valid, reg_write, is_load, dst}.
- A source "matches" entry k when all of these hold:
  - id_valid is 1 and the source's uses bit is 1;
  - the source address is nonzero;
  - entry k has valid=1 and reg_write=1;
  - entry k's dst equals the source address.
- Forwarding: an ID source matching entry k (1..DEPTH-1) forwards from entry k+1 when it reaches EX.
  - When several entries match, the youngest (smallest k) wins.
  - An entry-DEPTH match, or no match, selects 0; WB writes the register file before ID reads it.
- Load-use stall:
  - stall = !flush and (some source matches an entry k with is_load=1 and k+1 < LOAD_STAGE).
  - A load at entry k therefore stalls the consumer for LOAD_STAGE-1-k cycles.
- Update on each falling edge (rst=0):
  - entry[k] <= entry[k-1] for k = 2..DEPTH.
  - entry[1] <= bubble (all fields 0) if flush, stall or !id_valid; otherwise the ID fields.
  - ex_valid <= the valid bit written into entry[1].
  - fwd_*_ex <= the computed select if entry[1] receives a real instruction, else 0.
- Flush has priority over stall: the ID instruction is discarded and no stall is asserted. The branch in entry 1 advances normally.
- stall_cnt increments on every edge where stall=1; flush_cnt increments on every edge where flush=1. Both saturate at 0xFFFF.

## Timing
- Reset: on any falling edge with rst=1, the following clear to 0 regardless of other inputs:
  - all entries;
  - ex_valid, fwd_rs_ex, fwd_rt_ex;
  - stall_cnt, flush_cnt.
- During reset, stall and flush still follow their combinational equations. The scoreboard is empty, so stall=0; flush = ex_branch_taken.
- Reset mid-stall drops every in-flight entry. The stalled consumer is re-evaluated against the empty scoreboard and proceeds.
- stall and flush have zero latency from the ID and EX inputs.
- fwd and ex_valid have one edge of latency and are aligned with the ID/EX register.
- An instruction occupies entry k exactly k edges after leaving ID, unless reset intervenes.

## Test plan
- Reset: apply rst for 2 edges with random inputs.
  - Required: ex_valid, fwd_rs_ex, fwd_rt_ex, stall_cnt, flush_cnt all 0; stall=0.
- add $3 followed immediately by add $5,$3,$3:
  - Required: stall=0; after the edge, fwd_rs_ex=2 and fwd_rt_ex=2.
  - With one instruction in between: both selects = 3.
- lw $3 followed by sub $4,$3,$1 (defaults):
  - Required: stall=1 for exactly one cycle with a bubble in EX (ex_valid=0).
  - Then fwd_rs_ex=3, fwd_rt_ex=0, stall_cnt=1.
- ex_branch_taken=1 together with a load-use condition in ID:
  - Required: flush=1, stall=0, then ex_valid=0, flush_cnt=1, stall_cnt unchanged.
- Forwarding priority:
  - Producer with dst $0, consumer reading $0: fwd=0.
  - Two producers writing $7, one edge apart, then a consumer of $7: fwd=2 (youngest wins).
- Parameter sweep, DEPTH=5, LOAD_STAGE=4:
  - lw $2 then use of $2: two stall cycles, then fwd=4.
  - Drive 70000 flushes: flush_cnt holds at 0xFFFF.
